cmp_sched: RTL and testbench
============================

Name: cmp_sched

Overview:
- Round-robin scheduler that shares the single compare datapath (CMP flag unit producing n, z, sn) between NUM_REQ requesters.
- Accepts one compare request at a time via valid/ready and drives the registered operand and size fields into the shared unit.
- Samples the resulting flags one cycle later and returns them to the winning requester via a response handshake.
- Sits between the issue stage and the shared compare unit.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8
PTR_W, $clog2(NUM_REQ), round-robin pointer width (derived, do not override)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept
req_arg0  in  NUM_REQ*64  operand 0, requester i at [64*i +: 64]
req_arg1  in  NUM_REQ*64  operand 1, same packing
req_size0  in  NUM_REQ*2  operand 0 size (0=8b, 1=16b, 2=32b, 3=64b)
req_size1  in  NUM_REQ*2  operand 1 size, same packing
cmp_arg0  out  64  registered operand 0 to shared unit
cmp_arg1  out  64  registered operand 1 to shared unit
cmp_size0  out  2  registered size 0 to shared unit
cmp_size1  out  2  registered size 1 to shared unit
cmp_n  in  1  unsigned-less flag from shared unit
cmp_z  in  1  equal flag from shared unit
cmp_sn  in  1  signed-less flag from shared unit
rsp_valid  out  NUM_REQ  one-hot response valid
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_n  out  1  captured n flag
rsp_z  out  1  captured z flag
rsp_sn  out  1  captured sn flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0.
  - cmp_arg*/cmp_size*=0; rsp_n/z/sn=0; rsp_valid=0; req_ready=0; busy=0.
  - Reset mid-transaction drops the transaction silently.
- States: IDLE, EVAL, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready = one-hot(grant), combinational; zero if no valid.
  - On accept: latch that requester's arg0/arg1/size0/size1 into cmp_*, store grant index, go to EVAL.
- EVAL (exactly 1 cycle): cmp_* stable. At the clock edge, capture cmp_n/cmp_z/cmp_sn into rsp_*, go to RESP.
- RESP:
  - rsp_valid[grant]=1; rsp_* and cmp_* held.
  - On rsp_ready[grant]: ptr = (grant+1) mod NUM_REQ, go to IDLE.
  - rsp_ready of non-granted requesters is ignored.
- Latency: accept at cycle T, rsp_valid at T+2. Without fast path, minimum issue interval is 3 cycles.
- rsp_* flags keep their last captured value outside RESP; they are never cleared except by reset.
- req_ready is 0 in EVAL and RESP (except as allowed by the optional feature).
- Requesters must not make req_valid depend on req_ready.
- A requester that drops req_valid before accept is simply skipped.
- Once accepted, the operands are owned by the block, so requester inputs may change freely.
- Fairness: a requester that holds req_valid is granted within NUM_REQ grants.

Optional Feature:
CMP_SCHED_FASTPATH_EN
- Defined:
  - In RESP, in the same cycle rsp_ready[grant]=1, arbitration runs using the updated pointer (grant+1).
  - If any req_valid is set, req_ready is asserted, operands are latched, and the state goes directly to EVAL.
  - Issue interval drops to 2 cycles.
- Not defined: RESP always returns to IDLE; req_ready is never asserted outside IDLE.

Test Plan:
- Reset, then req_valid=0001, arg0=5, arg1=5, sizes=3 -> req_ready=0001 at T; at T+2 rsp_valid=0001 with rsp_z=1, rsp_n=0, rsp_sn=0.
- Requester 2: arg0=0xFF, arg1=0x01, size0=0 -> shared unit sign-extends to -1. At T+2: rsp_n=0, rsp_sn=1, rsp_z=0, rsp_valid=0100.
- req_valid=1111 held, rsp_ready=1111 -> grant order 0,1,2,3,0. Accept interval 3 cycles (2 with CMP_SCHED_FASTPATH_EN).
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_*, cmp_* stable, req_ready=0, busy=1. Raise rsp_ready -> IDLE next cycle.
- rst_n=0 asynchronously during EVAL -> all outputs 0 immediately. After release, req_valid=0010 is granted from ptr=0 scan -> req_ready=0010.
- Only requester 3 valid after grant to 3 -> wrap: ptr=0, requester 3 still granted next.

Source files
------------

// File: rtl/cmp_sched.sv
// cmp_sched: round-robin scheduler sharing one compare flag unit (n, z, sn) among NUM_REQ requesters
// Ports: clk, rst_n (async active-low); req_valid/req_ready + packed req_arg0/1, req_size0/1 (requester i at slice i);
//        cmp_arg0/1, cmp_size0/1 registered to the shared unit, cmp_n/z/sn flags back from it;
//        rsp_valid/rsp_ready one-hot response handshake with captured rsp_n/z/sn; busy when not IDLE.
// Option: define CMP_SCHED_FASTPATH_EN to let RESP re-arbitrate and jump straight to EVAL (2-cycle issue).
module cmp_sched #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*64-1:0]  req_arg0,
  input  logic [NUM_REQ*64-1:0]  req_arg1,
  input  logic [NUM_REQ*2-1:0]   req_size0,
  input  logic [NUM_REQ*2-1:0]   req_size1,
  output logic [63:0]            cmp_arg0,
  output logic [63:0]            cmp_arg1,
  output logic [1:0]             cmp_size0,
  output logic [1:0]             cmp_size1,
  input  logic                   cmp_n,
  input  logic                   cmp_z,
  input  logic                   cmp_sn,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic                   rsp_n,
  output logic                   rsp_z,
  output logic                   rsp_sn,
  output logic                   busy
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t state;
  logic [PTR_W-1:0] ptr, gnt, nxt_ptr, scan_ptr, sel;
  logic any, arb_en, done, accept;
  assign nxt_ptr = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
  assign done = state == RESP && rsp_ready[gnt];
`ifdef CMP_SCHED_FASTPATH_EN
  assign arb_en = rst_n && (state == IDLE || done);
  assign scan_ptr = state == RESP ? nxt_ptr : ptr;
`else
  assign arb_en = rst_n && state == IDLE;
  assign scan_ptr = ptr;
`endif
  // Scan from the highest offset down so the requester nearest the pointer wins last.
  always_comb begin
    int j;
    any = 1'b0;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(scan_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid[j]) begin
        any = 1'b1;
        sel = PTR_W'(j);
      end
    end
  end
  // rst_n gating keeps req_ready low while reset is held even with requests pending.
  assign accept = arb_en && any;
  assign req_ready = accept ? ONE << sel : '0;
  assign rsp_valid = state == RESP ? ONE << gnt : '0;
  assign busy = state != IDLE;
  // Later assignments win: a fast-path accept in RESP overrides the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      gnt <= '0;
      cmp_arg0 <= '0;
      cmp_arg1 <= '0;
      cmp_size0 <= '0;
      cmp_size1 <= '0;
      rsp_n <= 1'b0;
      rsp_z <= 1'b0;
      rsp_sn <= 1'b0;
    end else begin
      if (state == EVAL) begin
        rsp_n <= cmp_n;
        rsp_z <= cmp_z;
        rsp_sn <= cmp_sn;
        state <= RESP;
      end
      if (done) begin
        ptr <= nxt_ptr;
        state <= IDLE;
      end
      if (accept) begin
        cmp_arg0 <= req_arg0[64*sel +: 64];
        cmp_arg1 <= req_arg1[64*sel +: 64];
        cmp_size0 <= req_size0[2*sel +: 2];
        cmp_size1 <= req_size1[2*sel +: 2];
        gnt <= sel;
        state <= EVAL;
      end
    end
  end
endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched: scoreboard bench for cmp_sched with a behavioural shared compare unit
module tb_cmp_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [255:0] req_arg0, req_arg1;
  logic [7:0] req_size0, req_size1;
  logic [63:0] cmp_arg0, cmp_arg1;
  logic [1:0] cmp_size0, cmp_size1;
  logic cmp_n, cmp_z, cmp_sn, rsp_n, rsp_z, rsp_sn, busy;
  logic [63:0] a0 [4], a1 [4];
  logic [1:0] s0 [4], s1 [4];
  typedef struct {logic [3:0] oh; logic [2:0] f; logic [63:0] a0; int acc;} exp_t;
  exp_t q [$];
  int checks = 0, failures = 0, cyc = 0, last_acc = 0;
  logic [1:0] tb_ptr = '0;
`ifdef CMP_SCHED_FASTPATH_EN
  localparam int INTERVAL = 2;
`else
  localparam int INTERVAL = 3;
`endif
  cmp_sched #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_arg0(req_arg0), .req_arg1(req_arg1), .req_size0(req_size0), .req_size1(req_size1),
    .cmp_arg0(cmp_arg0), .cmp_arg1(cmp_arg1), .cmp_size0(cmp_size0), .cmp_size1(cmp_size1),
    .cmp_n(cmp_n), .cmp_z(cmp_z), .cmp_sn(cmp_sn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_sn(rsp_sn),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] ext(input logic [63:0] v, input logic [1:0] s, input logic sg);
    case (s)
      2'd0: return sg ? {{56{v[7]}}, v[7:0]} : {56'b0, v[7:0]};
      2'd1: return sg ? {{48{v[15]}}, v[15:0]} : {48'b0, v[15:0]};
      2'd2: return sg ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
      default: return v;
    endcase
  endfunction
  function automatic logic [2:0] flg(input logic [63:0] x, y, input logic [1:0] sx, sy);
    logic [63:0] ux, uy, gx, gy;
    ux = ext(x, sx, 1'b0);
    uy = ext(y, sy, 1'b0);
    gx = ext(x, sx, 1'b1);
    gy = ext(y, sy, 1'b1);
    return {ux < uy, ux == uy, $signed(gx) < $signed(gy)};
  endfunction
  assign {cmp_n, cmp_z, cmp_sn} = flg(cmp_arg0, cmp_arg1, cmp_size0, cmp_size1);
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_arg0[64*i +: 64] = a0[i];
      req_arg1[64*i +: 64] = a1[i];
      req_size0[2*i +: 2] = s0[i];
      req_size1[2*i +: 2] = s1[i];
    end
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_op(input int i, input logic [63:0] x, y, input logic [1:0] sx, sy);
    a0[i] = x;
    a1[i] = y;
    s0[i] = sx;
    s1[i] = sy;
  endtask
  // Drive a request mask, wait (bounded) for acceptance, check the grant and queue the expected response.
  task automatic issue(input logic [3:0] m, input logic drop);
    logic [1:0] g, idx;
    int k;
    g = tb_ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = tb_ptr + 2'(i);
      if (m[idx]) g = idx;
    end
    req_valid = m;
    k = 0;
    #1;
    while (req_ready == 4'b0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("grant", req_ready, 4'b1 << g);
    last_acc = cyc;
    q.push_back('{oh: 4'b1 << g, f: flg(a0[g], a1[g], s0[g], s1[g]), a0: a0[g], acc: cyc});
    tb_ptr = g + 2'd1;
    @(negedge clk);
    if (drop) req_valid = '0;
  endtask
  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain", 128'(q.size()), 128'd0);
  endtask
  logic [3:0] prev_rv = '0;
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rsp_valid != 4'b0 && prev_rv == 4'b0) begin
      if (q.size() != 0) begin
        check("latency", 128'(cyc - q[0].acc), 128'd2);
        check("cmp_arg0", cmp_arg0, q[0].a0);
      end else check("spurious_rsp", rsp_valid, 4'b0);
    end
    prev_rv = rsp_valid;
    if ((rsp_valid & rsp_ready) != 4'b0) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        check("rsp_valid", rsp_valid, e.oh);
        check("rsp_flags", {rsp_n, rsp_z, rsp_sn}, e.f);
      end else check("unexpected_rsp", rsp_valid & rsp_ready, 4'b0);
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int prev, k;
    for (int i = 0; i < 4; i++) set_op(i, 64'd0, 64'd0, 2'd0, 2'd0);
    req_valid = 4'hf;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", {req_ready, rsp_valid, busy, rsp_n, rsp_z, rsp_sn}, '0);
    check("rst_cmp", {cmp_arg0, cmp_arg1, cmp_size0, cmp_size1}, '0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    rsp_ready = 4'hf;
    @(negedge clk);
    set_op(0, 64'd5, 64'd5, 2'd3, 2'd3);
    issue(4'b0001, 1'b1);
    drain();
    check("t1_flags", {rsp_n, rsp_z, rsp_sn}, 3'b010);
    set_op(2, 64'hff, 64'h01, 2'd0, 2'd0);
    issue(4'b0100, 1'b1);
    drain();
    check("t2_flags", {rsp_n, rsp_z, rsp_sn}, 3'b001);
    set_op(3, 64'd3, 64'h1234, 2'd3, 2'd3);
    issue(4'b1000, 1'b1);
    drain();
    issue(4'b1000, 1'b1);
    drain();
    set_op(1, 64'h8000, 64'h0001, 2'd1, 2'd1);
    for (int i = 0; i < 5; i++) begin
      prev = last_acc;
      issue(4'hf, i == 4);
      if (i > 0) check("interval", 128'(last_acc - prev), 128'(INTERVAL));
    end
    drain();
    rsp_ready = '0;
    issue(4'b0100, 1'b1);
    k = 0;
    #1;
    while (rsp_valid == 4'b0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rsp_wait", rsp_valid != 4'b0, 1'b1);
    @(negedge clk);
    req_valid = 4'hf;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold", {rsp_valid, rsp_n, rsp_z, rsp_sn, cmp_arg0, req_ready, busy},
            {q[0].oh, q[0].f, q[0].a0, 4'b0, 1'b1});
      @(negedge clk);
    end
    rsp_ready = 4'hf;
    req_valid = '0;
    @(negedge clk);
    #1;
    check("resp_to_idle", {busy, rsp_valid}, 5'b0);
    drain();
    @(negedge clk);
    issue(4'b0001, 1'b1);
    req_valid = 4'hf;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {req_ready, rsp_valid, busy, rsp_n, rsp_z, rsp_sn}, '0);
    check("async_rst_cmp", {cmp_arg0, cmp_arg1, cmp_size0, cmp_size1}, '0);
    q.delete();
    tb_ptr = '0;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    set_op(1, 64'd7, 64'd9, 2'd2, 2'd2);
    issue(4'b0010, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
